seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_if.sv | 23 ++
 rtl/seq_multiplier.sv | 121 ++++++++++++
 tb/tb_seq_multiplier.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for seq_multiplier: start request, operands, busy/done status and product.
// The master drives the request side; the multiplier is the slave.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 busy_o;
    logic                 done_o;
    logic [2*WIDTH-1:0]   product_o;

    modport master (
        output start_i, signed_i, a_i, b_i,
        input  busy_o, done_o, product_o
    );

    modport slave (
        input  start_i, signed_i, a_i, b_i,
        output busy_o, done_o, product_o
    );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier: WIDTH iterations per operation, one-cycle done pulse.
// Define SEQ_MULT_SIGNED_EN to add two's-complement support (selected per operation by signed_i).
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    seq_multiplier_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int ACC_W = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_mcand;
    logic [ACC_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [ACC_W-1:0]     w_acc_next;
    logic [2*WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_next_state = S_RUN;
                    w_accept     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.start_i) begin
                    w_next_state = S_RUN;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Multiplier sits in the low half of the accumulator and shifts out as the product shifts in.
    assign w_sum      = r_acc[ACC_W-1:WIDTH] + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {1'b0, w_sum, r_acc[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
    logic r_neg;
    logic w_neg;

    // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits WIDTH unsigned bits.
    assign w_a_mag  = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
    assign w_b_mag  = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
    assign w_neg    = bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
    assign w_result = r_neg ? -w_acc_next[2*WIDTH-1:0] : w_acc_next[2*WIDTH-1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_neg;
        end
    end
`else
    assign w_a_mag  = bus.a_i;
    assign w_b_mag  = bus.b_i;
    assign w_result = w_acc_next[2*WIDTH-1:0];
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand <= w_a_mag;
            r_acc   <= {{(WIDTH + 1){1'b0}}, w_b_mag};
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_product <= w_result;
            end
        end
    end

    assign bus.busy_o    = (r_state == S_RUN);
    assign bus.done_o    = (r_state == S_DONE);
    assign bus.product_o = r_product;
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH 8, 16 and 2: directed table, corner sequences,
// and random operands compared against an arithmetic reference model.
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(8))  if8 ();
    seq_multiplier_if #(.WIDTH(16)) if16 ();
    seq_multiplier_if #(.WIDTH(2))  if2 ();

    seq_multiplier #(.WIDTH(8))  u_dut8  (.wb_clk_i(clk), .wb_rst_i(rst), .bus(if8));
    seq_multiplier #(.WIDTH(16)) u_dut16 (.wb_clk_i(clk), .wb_rst_i(rst), .bus(if16));
    seq_multiplier #(.WIDTH(2))  u_dut2  (.wb_clk_i(clk), .wb_rst_i(rst), .bus(if2));

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Mathematical product of the operands as interpreted (signed only when the feature is built in).
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        longint ia, ib, mask;
        mask = (longint'(1) << w) - 1;
        ia   = longint'(a) & mask;
        ib   = longint'(b) & mask;
`ifdef SEQ_MULT_SIGNED_EN
        if (s) begin
            if (ia[w-1]) ia = ia - (longint'(1) << w);
            if (ib[w-1]) ib = ib - (longint'(1) << w);
        end
`endif
        return 32'((ia * ib) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Counts clocks until done_o, noting whether busy_o stayed high while waiting.
    task automatic wait_done8(output int n, output logic busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (!if8.done_o && n < 40) begin
            if (!if8.busy_o) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input string name);
        int   n;
        logic busy_ok;
        @(negedge clk);
        if8.start_i  = 1'b1;
        if8.a_i      = a;
        if8.b_i      = b;
        if8.signed_i = s;
        @(posedge clk); #1;
        if8.start_i  = 1'b0;
        if8.a_i      = 8'($urandom);
        if8.b_i      = 8'($urandom);
        if8.signed_i = 1'($urandom);
        wait_done8(n, busy_ok);
        check({name, " latency"}, 32'(n), 32'd8);
        check({name, " busy"}, {31'd0, busy_ok & ~if8.busy_o}, 32'd1);
        check({name, " product"}, {16'd0, if8.product_o}, {16'd0, exp});
        @(posedge clk); #1;
        check({name, " done pulse"}, {31'd0, if8.done_o}, 32'd0);
        check({name, " hold"}, {16'd0, if8.product_o}, {16'd0, exp});
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input string name);
        int n;
        @(negedge clk);
        if16.start_i = 1'b1;
        if16.a_i     = a;
        if16.b_i     = b;
        @(posedge clk); #1;
        if16.start_i = 1'b0;
        n = 0;
        while (!if16.done_o && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd16);
        check({name, " product"}, if16.product_o, exp);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic s,
                       input logic [3:0] exp, input string name);
        int n;
        @(negedge clk);
        if2.start_i  = 1'b1;
        if2.a_i      = a;
        if2.b_i      = b;
        if2.signed_i = s;
        @(posedge clk); #1;
        if2.start_i = 1'b0;
        n = 0;
        while (!if2.done_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'd2);
        check({name, " product"}, {28'd0, if2.product_o}, {28'd0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected to finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic        busy_ok;
        logic        saw_done;
        logic [7:0]  ra, rb;
        logic [15:0] ra16, rb16;
        logic        rs;
        logic [31:0] m;

        if8.start_i = 1'b0;  if8.signed_i = 1'b0;  if8.a_i = '0;  if8.b_i = '0;
        if16.start_i = 1'b0; if16.signed_i = 1'b0; if16.a_i = '0; if16.b_i = '0;
        if2.start_i = 1'b0;  if2.signed_i = 1'b0;  if2.a_i = '0;  if2.b_i = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, if8.busy_o}, 32'd0);
        check("reset done", {31'd0, if8.done_o}, 32'd0);
        check("reset product", {16'd0, if8.product_o}, 32'd0);
        check("reset product16", if16.product_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{a: 8'd13,   b: 8'd11,   sgn: 1'b0, exp: 16'h008F});
        tbl.push_back('{a: 8'd255,  b: 8'd255,  sgn: 1'b0, exp: 16'hFE01});
        tbl.push_back('{a: 8'd0,    b: 8'd200,  sgn: 1'b0, exp: 16'h0000});
        tbl.push_back('{a: 8'd1,    b: 8'd1,    sgn: 1'b0, exp: 16'h0001});
        tbl.push_back('{a: 8'h80,   b: 8'd2,    sgn: 1'b0, exp: 16'h0100});
        tbl.push_back('{a: 8'hFD,   b: 8'd5,    sgn: 1'b0, exp: 16'h04F1});
`ifdef SEQ_MULT_SIGNED_EN
        tbl.push_back('{a: 8'hFD,   b: 8'd5,    sgn: 1'b1, exp: 16'hFFF1});
        tbl.push_back('{a: 8'h80,   b: 8'h80,   sgn: 1'b1, exp: 16'h4000});
        tbl.push_back('{a: 8'h7F,   b: 8'h80,   sgn: 1'b1, exp: 16'hC080});
        tbl.push_back('{a: 8'hFF,   b: 8'hFF,   sgn: 1'b1, exp: 16'h0001});
`else
        tbl.push_back('{a: 8'hFD,   b: 8'd5,    sgn: 1'b1, exp: 16'h04F1});
`endif
        foreach (tbl[i]) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Back-to-back: restart during the DONE cycle.
        @(negedge clk);
        if8.start_i = 1'b1; if8.a_i = 8'd255; if8.b_i = 8'd255; if8.signed_i = 1'b0;
        @(posedge clk); #1;
        if8.start_i = 1'b0;
        wait_done8(n, busy_ok);
        check("b2b first latency", 32'(n), 32'd8);
        check("b2b first product", {16'd0, if8.product_o}, 32'h0000FE01);
        if8.start_i = 1'b1; if8.a_i = 8'd0; if8.b_i = 8'd200;
        @(posedge clk); #1;
        if8.start_i = 1'b0;
        check("b2b restart busy", {31'd0, if8.busy_o}, 32'd1);
        wait_done8(n, busy_ok);
        check("b2b done spacing", 32'(n + 1), 32'd9);
        check("b2b second product", {16'd0, if8.product_o}, 32'd0);

        // start_i held high through busy with changing operands.
        @(negedge clk);
        if8.start_i = 1'b1; if8.a_i = 8'd13; if8.b_i = 8'd11;
        @(posedge clk); #1;
        n = 0;
        while (!if8.done_o && n < 40) begin
            if8.a_i = 8'($urandom);
            if8.b_i = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        check("held start latency", 32'(n), 32'd8);
        check("held start product", {16'd0, if8.product_o}, 32'd143);
        if8.a_i = 8'd7; if8.b_i = 8'd6;
        @(posedge clk); #1;
        if8.start_i = 1'b0;
        check("held start restart busy", {31'd0, if8.busy_o}, 32'd1);
        wait_done8(n, busy_ok);
        check("held start second latency", 32'(n), 32'd8);
        check("held start second product", {16'd0, if8.product_o}, 32'd42);

        // Reset sampled at iteration 4 discards the operation.
        @(negedge clk);
        if8.start_i = 1'b1; if8.a_i = 8'd200; if8.b_i = 8'd100;
        @(posedge clk); #1;
        if8.start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun reset busy", {31'd0, if8.busy_o}, 32'd0);
        check("midrun reset done", {31'd0, if8.done_o}, 32'd0);
        check("midrun reset product", {16'd0, if8.product_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
            if (if8.done_o) saw_done = 1'b1;
        end
        check("midrun reset no done", {31'd0, saw_done}, 32'd0);
        op8(8'd200, 8'd100, 1'b0, 16'd20000, "post reset");

        repeat (40) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            m  = ref_mul(8, {8'd0, ra}, {8'd0, rb}, rs);
            op8(ra, rb, rs, m[15:0], $sformatf("rnd8 %0h*%0h s%0d", ra, rb, rs));
        end

        op16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16 max");
        repeat (8) begin
            ra16 = 16'($urandom);
            rb16 = 16'($urandom);
            op16(ra16, rb16, ref_mul(16, ra16, rb16, 1'b0), $sformatf("rnd16 %0h*%0h", ra16, rb16));
        end

        op2(2'd3, 2'd3, 1'b0, 4'd9, "w2 max");
        for (int i = 0; i < 32; i++) begin
            m = ref_mul(2, 16'(i & 3), 16'((i >> 2) & 3), 1'(i >> 4));
            op2(2'(i & 3), 2'((i >> 2) & 3), 1'(i >> 4), m[3:0], $sformatf("w2 case%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
